// File: rtl/gestor_chamadas_if.sv
// Signal bundle between the call/door manager and the surrounding elevator
// system: call buttons, door sensor, floor feedback from the elevator FSM,
// and the call/freeze/status outputs back towards it.
interface gestor_chamadas_if;

  // Inputs towards the manager
  logic btn_t;
  logic btn_1;
  logic btn_2;
  logic btn_3;
  logic obstrucao;
  logic AndarB1;
  logic AndarB0;

  // Outputs from the manager
  logic At;
  logic A1;
  logic A2;
  logic A3;
  logic Erro;
  logic porta_aberta;
  logic falha;

  // Environment side: drives buttons, sensor and floor, observes outputs
  modport master (
    output btn_t, btn_1, btn_2, btn_3, obstrucao, AndarB1, AndarB0,
    input  At, A1, A2, A3, Erro, porta_aberta, falha
  );

  // Manager side
  modport slave (
    input  btn_t, btn_1, btn_2, btn_3, obstrucao, AndarB1, AndarB0,
    output At, A1, A2, A3, Erro, porta_aberta, falha
  );

endinterface : gestor_chamadas_if

// File: rtl/gestor_chamadas.sv
// Call/door manager sitting in front of the elevator FSM.
// Latches floor calls, presents them as At/A1/A2/A3, clears a call when the
// car is at that floor (opening the door), and freezes the FSM through Erro
// while the door is open or after a movement timeout fault.
module gestor_chamadas #(
  parameter int DOOR_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  gestor_chamadas_if.slave  bus
);

  // Timer widths; a single-cycle door still needs a one-bit register
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int MW = $clog2(TIMEOUT_CYCLES);

  localparam logic [DW-1:0] DR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [MW-1:0] MV_LAST = MW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVING,
    ST_DOOR_OPEN,
    ST_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      req_q, req_d;
  logic [1:0]      floor_prev_q;
  logic [DW-1:0]   dr_tmr_q, dr_tmr_d;
  logic [MW-1:0]   mv_tmr_q, mv_tmr_d;

  // Registered outputs
  logic [3:0]      calls_q;
  logic            erro_q;
  logic            porta_q;
  logic            falha_q;

  // Combinational helpers
  logic [1:0]      floor;
  logic [3:0]      btn;
  logic [3:0]      floor_oh;
  logic [3:0]      btn_eff;
  logic [3:0]      clr;
  logic            call_here;

  assign floor     = {bus.AndarB1, bus.AndarB0};
  assign btn       = {bus.btn_3, bus.btn_2, bus.btn_1, bus.btn_t};
  assign floor_oh  = 4'b0001 << floor;
  assign call_here = |(req_q & floor_oh);

  // Next-state, timer and request computation
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_d  = state_q;
    dr_tmr_d = dr_tmr_q;
    mv_tmr_d = mv_tmr_q;
    clr      = 4'b0000;
    btn_eff  = btn;

    unique case (state_q)
      ST_IDLE: begin
        if (call_here) begin
          state_d  = ST_DOOR_OPEN;
          clr      = floor_oh;
          dr_tmr_d = DR_LOAD;
        end else if (req_q != 4'b0000) begin
          state_d  = ST_MOVING;
          mv_tmr_d = '0;
        end
      end

      ST_MOVING: begin
        if (call_here) begin
          state_d  = ST_DOOR_OPEN;
          clr      = floor_oh;
          dr_tmr_d = DR_LOAD;
        end else if (req_q == 4'b0000) begin
          state_d  = ST_IDLE;
        end else if (floor != floor_prev_q) begin
          // Car is progressing: restart the stall watchdog
          mv_tmr_d = '0;
        end else if (mv_tmr_q == MV_LAST) begin
          state_d  = ST_FAULT;
        end else begin
          mv_tmr_d = mv_tmr_q + MW'(1);
        end
      end

      ST_DOOR_OPEN: begin
        // A press for the floor we are standing at only holds the door open
        btn_eff = btn & ~floor_oh;
        if (bus.obstrucao || (|(btn & floor_oh))) begin
          dr_tmr_d = DR_LOAD;
        end else if (dr_tmr_q == '0) begin
          if (req_q != 4'b0000) begin
            state_d  = ST_MOVING;
            mv_tmr_d = '0;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          dr_tmr_d = dr_tmr_q - DW'(1);
        end
      end

      ST_FAULT: begin
        // Absorbing; only reset leaves this state
      end

      default: state_d = ST_IDLE;
    endcase

    // Clearing the served floor wins over a simultaneous press of it
    req_d = (req_q | btn_eff) & ~clr;
  end

  // State, timers, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q      <= ST_IDLE;
      req_q        <= 4'b0000;
      floor_prev_q <= 2'b00;
      dr_tmr_q     <= '0;
      mv_tmr_q     <= '0;
      calls_q      <= 4'b0000;
      erro_q       <= 1'b0;
      porta_q      <= 1'b0;
      falha_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      floor_prev_q <= floor;
      dr_tmr_q     <= dr_tmr_d;
      mv_tmr_q     <= mv_tmr_d;
      calls_q      <= (state_d == ST_FAULT) ? 4'b0000 : req_d;
      erro_q       <= (state_d == ST_DOOR_OPEN) || (state_d == ST_FAULT);
      porta_q      <= (state_d == ST_DOOR_OPEN);
      falha_q      <= (state_d == ST_FAULT);
    end
  end

  assign bus.At           = calls_q[0];
  assign bus.A1           = calls_q[1];
  assign bus.A2           = calls_q[2];
  assign bus.A3           = calls_q[3];
  assign bus.Erro         = erro_q;
  assign bus.porta_aberta = porta_q;
  assign bus.falha        = falha_q;

endmodule : gestor_chamadas

// File: tb/tb_gestor_chamadas.sv
// Directed bench for gestor_chamadas. Inputs are driven and outputs sampled
// on the falling clock edge; expected values go into a scoreboard queue when
// the stimulus is applied and are popped and compared once the DUT responds.
module tb_gestor_chamadas;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gestor_chamadas_if bus ();

  gestor_chamadas #(
    .DOOR_CYCLES    (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Packs {falha, porta_aberta, Erro, A3, A2, A1, At}
  function automatic int unsigned vec(logic fl, logic pa, logic er, logic [3:0] c);
    return {25'd0, fl, pa, er, c};
  endfunction

  function automatic int unsigned outs();
    return {25'd0, bus.falha, bus.porta_aberta, bus.Erro,
            bus.A3, bus.A2, bus.A1, bus.At};
  endfunction

  task automatic push_exp(input string tag, input int unsigned val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int unsigned observed);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty observed=%0h expected=<none>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val) else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_floor(input logic [1:0] f);
    bus.AndarB1 = f[1];
    bus.AndarB0 = f[0];
  endtask

  task automatic wait_open(input int bound, output int unsigned ok);
    for (int i = 0; i < bound && !bus.porta_aberta; i++) step(1);
    ok = bus.porta_aberta;
  endtask

  // Counts cycles the door stays open, starting in a cycle where it is open
  task automatic door_len(output int unsigned cnt);
    cnt = 0;
    while (bus.porta_aberta && cnt < 200) begin
      cnt++;
      step(1);
    end
  endtask

  int unsigned ok;
  int unsigned cnt;
  int unsigned a2_seen;

  // Overall time guard so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset         = 1'b1;
    bus.btn_t     = 1'b0;
    bus.btn_1     = 1'b0;
    bus.btn_2     = 1'b0;
    bus.btn_3     = 1'b0;
    bus.obstrucao = 1'b0;
    set_floor(2'd0);

    // Reset state
    step(2);
    push_exp("reset_outputs", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());
    reset = 1'b0;
    step(1);
    push_exp("idle_outputs", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    // 1: call to floor 2 from floor 0, A2 next cycle, no freeze while moving
    bus.btn_2 = 1'b1;
    push_exp("t1_a2_latched", vec(0, 0, 0, 4'b0100));
    step(1);
    bus.btn_2 = 1'b0;
    pop_cmp(outs());
    push_exp("t1_moving", vec(0, 0, 0, 4'b0100));
    step(1);
    pop_cmp(outs());
    set_floor(2'd2);
    push_exp("t1_door_opened", 1);
    wait_open(10, ok);
    pop_cmp(ok);
    push_exp("t1_door_outputs", vec(0, 1, 1, 4'b0000));
    pop_cmp(outs());
    push_exp("t1_door_len", 8);
    door_len(cnt);
    pop_cmp(cnt);
    push_exp("t1_back_idle", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    // 2: call at the current floor opens the door for exactly DOOR_CYCLES
    set_floor(2'd0);
    step(1);
    bus.btn_t = 1'b1;
    step(1);
    bus.btn_t = 1'b0;
    push_exp("t2_door_opened", 1);
    wait_open(10, ok);
    pop_cmp(ok);
    push_exp("t2_door_outputs", vec(0, 1, 1, 4'b0000));
    pop_cmp(outs());
    push_exp("t2_door_len", 8);
    door_len(cnt);
    pop_cmp(cnt);
    push_exp("t2_back_idle", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    // 3: two simultaneous calls; floor 1 served on the way, floor 3 stays
    bus.btn_1 = 1'b1;
    bus.btn_3 = 1'b1;
    push_exp("t3_both_latched", vec(0, 0, 0, 4'b1010));
    step(1);
    bus.btn_1 = 1'b0;
    bus.btn_3 = 1'b0;
    pop_cmp(outs());
    step(1);
    set_floor(2'd1);
    push_exp("t3_door_opened", 1);
    wait_open(10, ok);
    pop_cmp(ok);
    push_exp("t3_door_a3_kept", vec(0, 1, 1, 4'b1000));
    pop_cmp(outs());
    push_exp("t3_door_len", 8);
    door_len(cnt);
    pop_cmp(cnt);
    push_exp("t3_moving_again", vec(0, 0, 0, 4'b1000));
    pop_cmp(outs());
    set_floor(2'd3);
    push_exp("t3_door3_opened", 1);
    wait_open(10, ok);
    pop_cmp(ok);
    push_exp("t3_door3_outputs", vec(0, 1, 1, 4'b0000));
    pop_cmp(outs());
    door_len(cnt);
    push_exp("t3_back_idle", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    // 4: obstruction for 20 door cycles, then a same-floor press 3 cycles
    // into the countdown: 20 + 3 + 1 (reload cycle) + 8 = 32 cycles open.
    // Same-floor presses during the door never latch A2.
    set_floor(2'd2);
    step(1);
    bus.btn_2 = 1'b1;
    step(1);
    bus.btn_2 = 1'b0;
    push_exp("t4_door_opened", 1);
    wait_open(10, ok);
    pop_cmp(ok);
    cnt     = 0;
    a2_seen = 0;
    for (int c = 0; c < 200 && bus.porta_aberta; c++) begin
      bus.obstrucao = (c < 20);
      bus.btn_2     = (c == 10) || (c == 23);
      if (bus.A2 !== 1'b0) a2_seen = 1;
      cnt++;
      step(1);
    end
    bus.obstrucao = 1'b0;
    bus.btn_2     = 1'b0;
    push_exp("t4_door_len", 32);
    pop_cmp(cnt);
    push_exp("t4_a2_never_set", 0);
    pop_cmp(a2_seen);
    push_exp("t4_back_idle", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    // 5: stall with a pending call -> fault after TIMEOUT_CYCLES in MOVING
    set_floor(2'd0);
    step(1);
    bus.btn_3 = 1'b1;
    step(1);
    bus.btn_3 = 1'b0;
    step(62);
    push_exp("t5_still_moving", vec(0, 0, 0, 4'b1000));
    pop_cmp(outs());
    step(4);
    push_exp("t5_fault", vec(1, 0, 1, 4'b0000));
    pop_cmp(outs());
    bus.btn_t = 1'b1;
    bus.btn_1 = 1'b1;
    bus.btn_2 = 1'b1;
    bus.btn_3 = 1'b1;
    step(2);
    bus.btn_t = 1'b0;
    bus.btn_1 = 1'b0;
    bus.btn_2 = 1'b0;
    bus.btn_3 = 1'b0;
    push_exp("t5_fault_sticky", vec(1, 0, 1, 4'b0000));
    pop_cmp(outs());
    reset = 1'b1;
    step(1);
    push_exp("t5_reset_clears", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());
    reset = 1'b0;
    step(1);
    push_exp("t5_idle_after_reset", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    // 6: same-floor press held across door entry is cleared; reset mid door
    set_floor(2'd1);
    step(1);
    bus.btn_1 = 1'b1;
    step(2);
    bus.btn_1 = 1'b0;
    push_exp("t6_door_a1_cleared", vec(0, 1, 1, 4'b0000));
    pop_cmp(outs());
    bus.btn_3 = 1'b1;
    step(1);
    bus.btn_3 = 1'b0;
    push_exp("t6_door_a3_pending", vec(0, 1, 1, 4'b1000));
    pop_cmp(outs());
    reset = 1'b1;
    step(1);
    push_exp("t6_reset_mid_door", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());
    reset = 1'b0;
    step(1);
    push_exp("t6_calls_lost", vec(0, 0, 0, 4'b0000));
    pop_cmp(outs());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_gestor_chamadas
